// File: rtl/salsa20.sv
// Salsa20 stream-cipher engine: register-mapped key/nonce/setup, one double round per cycle,
// 64-bit XOR data path. Define SALSA20_KEY256_EN to enable 256-bit keys via SETUP[0].
module salsa20 (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        data_encdec,
    input  logic        write_enable,
    input  logic [2:0]  address,
    input  logic [63:0] in,
    output logic        valid,
    output logic        ready,
    output logic        initialized,
    output logic [63:0] out
);

    typedef logic [15:0][31:0] state_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRound,
        StFinal,
        StReady
    } fsm_e;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Bus words carry stream byte 0 in the MSB; Salsa words are little-endian.
    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
        logic [31:0] a1, b1, c1, d1;
        b1 = b ^ rotl(a + d, 7);
        c1 = c ^ rotl(b1 + a, 9);
        d1 = d ^ rotl(c1 + b1, 13);
        a1 = a ^ rotl(d1 + c1, 18);
        return {a1, b1, c1, d1};
    endfunction

    function automatic state_t double_round(input state_t s);
        state_t t;
        t = s;
        {t[0],  t[4],  t[8],  t[12]} = qr(t[0],  t[4],  t[8],  t[12]);
        {t[5],  t[9],  t[13], t[1]}  = qr(t[5],  t[9],  t[13], t[1]);
        {t[10], t[14], t[2],  t[6]}  = qr(t[10], t[14], t[2],  t[6]);
        {t[15], t[3],  t[7],  t[11]} = qr(t[15], t[3],  t[7],  t[11]);
        {t[0],  t[1],  t[2],  t[3]}  = qr(t[0],  t[1],  t[2],  t[3]);
        {t[5],  t[6],  t[7],  t[4]}  = qr(t[5],  t[6],  t[7],  t[4]);
        {t[10], t[11], t[8],  t[9]}  = qr(t[10], t[11], t[8],  t[9]);
        {t[15], t[12], t[13], t[14]} = qr(t[15], t[12], t[13], t[14]);
        return t;
    endfunction

    function automatic state_t build(input logic [63:0] k0, input logic [63:0] k1,
                                     input logic [63:0] k2, input logic [63:0] k3,
                                     input logic [63:0] nonce, input logic k256);
        state_t      s;
        logic [63:0] hi0, hi1;
        hi0   = k256 ? k2 : k0;
        hi1   = k256 ? k3 : k1;
        s[0]  = 32'h61707865;
        s[5]  = k256 ? 32'h3320646e : 32'h3120646e;
        s[10] = k256 ? 32'h79622d32 : 32'h79622d36;
        s[15] = 32'h6b206574;
        s[1]  = bswap(k0[63:32]);
        s[2]  = bswap(k0[31:0]);
        s[3]  = bswap(k1[63:32]);
        s[4]  = bswap(k1[31:0]);
        s[6]  = bswap(nonce[63:32]);
        s[7]  = bswap(nonce[31:0]);
        s[8]  = 32'h0;
        s[9]  = 32'h0;
        s[11] = bswap(hi0[63:32]);
        s[12] = bswap(hi0[31:0]);
        s[13] = bswap(hi1[63:32]);
        s[14] = bswap(hi1[31:0]);
        return s;
    endfunction

    // Configuration registers (not reset)
    logic [63:0] key0_q, key0_d, key1_q, key1_d;
    logic [63:0] nonce_q, nonce_d;
    logic [3:0]  dr_q, dr_d;
    logic [63:0] key2_v, key3_v;
    logic        use256;

`ifdef SALSA20_KEY256_EN
    logic [63:0] key2_q, key2_d, key3_q, key3_d;
    logic        k256_q, k256_d;
`endif

    always_comb begin
        key0_d  = key0_q;
        key1_d  = key1_q;
        nonce_d = nonce_q;
        dr_d    = dr_q;
`ifdef SALSA20_KEY256_EN
        key2_d  = key2_q;
        key3_d  = key3_q;
        k256_d  = k256_q;
`endif
        if (write_enable) begin
            case (address)
                3'd0: key0_d = in;
                3'd1: key1_d = in;
`ifdef SALSA20_KEY256_EN
                3'd2: key2_d = in;
                3'd3: key3_d = in;
`endif
                3'd4: nonce_d = in;
                3'd5: begin
                    dr_d = in[4:1];
`ifdef SALSA20_KEY256_EN
                    k256_d = in[0];
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        key0_q  <= key0_d;
        key1_q  <= key1_d;
        nonce_q <= nonce_d;
        dr_q    <= dr_d;
`ifdef SALSA20_KEY256_EN
        key2_q  <= key2_d;
        key3_q  <= key3_d;
        k256_q  <= k256_d;
`endif
    end

    // init is built from the next-state values so a same-cycle write is seen
`ifdef SALSA20_KEY256_EN
    assign use256 = k256_d;
    assign key2_v = key2_d;
    assign key3_v = key3_d;
`else
    assign use256 = 1'b0;
    assign key2_v = key0_d;
    assign key3_v = key1_d;
`endif

    fsm_e        state_q, state_d;
    state_t      x_q, x_d;
    state_t      in_q, in_d;
    logic [3:0]  rounds_q, rounds_d;
    logic [3:0]  rnd_q, rnd_d;
    logic [2:0]  idx_q, idx_d;
    logic [63:0] out_q, out_d;
    logic        valid_q, valid_d;
    logic        init_done_q, init_done_d;
    logic [63:0] chunk;
    logic [63:0] ctr_next;

    assign chunk    = {bswap(x_q[{idx_q, 1'b0}]), bswap(x_q[{idx_q, 1'b1}])};
    assign ctr_next = {in_q[9], in_q[8]} + 64'd1;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        in_d        = in_q;
        rounds_d    = rounds_q;
        rnd_d       = rnd_q;
        idx_d       = idx_q;
        out_d       = out_q;
        valid_d     = 1'b0;
        init_done_d = init_done_q;
        if (init) begin
            state_d     = StLoad;
            in_d        = build(key0_d, key1_d, key2_v, key3_v, nonce_d, use256);
            rounds_d    = (dr_d == 4'd0) ? 4'd10 : dr_d;
            idx_d       = 3'd0;
            init_done_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: ;
                StLoad: begin
                    x_d     = in_q;
                    rnd_d   = rounds_q;
                    state_d = StRound;
                end
                StRound: begin
                    x_d   = double_round(x_q);
                    rnd_d = rnd_q - 4'd1;
                    if (rnd_q == 4'd1) begin
                        state_d = StFinal;
                    end
                end
                StFinal: begin
                    for (int i = 0; i < 16; i++) begin
                        x_d[i] = x_q[i] + in_q[i];
                    end
                    idx_d   = 3'd0;
                    state_d = StReady;
                end
                StReady: begin
                    if (data_encdec) begin
                        out_d   = in ^ chunk;
                        valid_d = 1'b1;
                        idx_d   = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            in_d[8] = ctr_next[31:0];
                            in_d[9] = ctr_next[63:32];
                            state_d = StLoad;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q         <= '0;
            in_q        <= '0;
            rounds_q    <= 4'd0;
            rnd_q       <= 4'd0;
            idx_q       <= 3'd0;
            out_q       <= 64'd0;
            valid_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            in_q        <= in_d;
            rounds_q    <= rounds_d;
            rnd_q       <= rnd_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            init_done_q <= init_done_d;
        end
    end

    assign out         = out_q;
    assign valid       = valid_q;
    assign ready       = (state_q == StReady);
    assign initialized = init_done_q;

endmodule

// File: tb/tb_salsa20.sv
// Self-checking bench for salsa20: reference keystream model feeding a scoreboard queue.
module tb_salsa20;

    logic        clk = 1'b0;
    logic        rst, init, data_encdec, write_enable;
    logic [2:0]  address;
    logic [63:0] in_w;
    logic        valid, ready, initialized;
    logic [63:0] out_w;

    always #5 clk = ~clk;

    salsa20 dut (
        .clk          (clk),
        .rst          (rst),
        .init         (init),
        .data_encdec  (data_encdec),
        .write_enable (write_enable),
        .address      (address),
        .in           (in_w),
        .valid        (valid),
        .ready        (ready),
        .initialized  (initialized),
        .out          (out_w)
    );

    int checks = 0;
    int errors = 0;

    localparam int QT [32] = '{0, 4, 8, 12,  5, 9, 13, 1,  10, 14, 2, 6,  15, 3, 7, 11,
                               0, 1, 2, 3,   5, 6, 7, 4,   10, 11, 8, 9,  15, 12, 13, 14};

    logic [63:0] cfg_key [4];
    logic [63:0] cfg_nonce, cfg_setup;
    logic [7:0]  m_key [32];
    logic [7:0]  m_nonce [8];
    logic        m_k256;
    int          m_d;
    logic [63:0] m_ctr;
    int          m_idx;
    logic [7:0]  m_ks [64];
    logic [63:0] sb [$];
    logic [63:0] pt [88];
    logic [63:0] ct [88];

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] kw(input int o);
        return {m_key[o+3], m_key[o+2], m_key[o+1], m_key[o]};
    endfunction

    task automatic gen_block();
        logic [31:0] s [16];
        logic [31:0] x [16];
        logic [31:0] w;
        s[0]  = 32'h61707865;
        s[5]  = m_k256 ? 32'h3320646e : 32'h3120646e;
        s[10] = m_k256 ? 32'h79622d32 : 32'h79622d36;
        s[15] = 32'h6b206574;
        for (int i = 0; i < 4; i++) begin
            s[1+i]  = kw(4 * i);
            s[11+i] = m_k256 ? kw(16 + 4 * i) : kw(4 * i);
        end
        s[6] = {m_nonce[3], m_nonce[2], m_nonce[1], m_nonce[0]};
        s[7] = {m_nonce[7], m_nonce[6], m_nonce[5], m_nonce[4]};
        s[8] = m_ctr[31:0];
        s[9] = m_ctr[63:32];
        x = s;
        for (int r = 0; r < m_d; r++) begin
            for (int q = 0; q < 8; q++) begin
                int a, b, c, d;
                a = QT[4*q]; b = QT[4*q+1]; c = QT[4*q+2]; d = QT[4*q+3];
                x[b] = x[b] ^ rotl(x[a] + x[d], 7);
                x[c] = x[c] ^ rotl(x[b] + x[a], 9);
                x[d] = x[d] ^ rotl(x[c] + x[b], 13);
                x[a] = x[a] ^ rotl(x[d] + x[c], 18);
            end
        end
        for (int i = 0; i < 16; i++) begin
            w = x[i] + s[i];
            for (int k = 0; k < 4; k++) m_ks[4*i+k] = w[8*k +: 8];
        end
    endtask

    task automatic latch_cfg();
        for (int n = 0; n < 4; n++)
            for (int b = 0; b < 8; b++) m_key[8*n+b] = cfg_key[n][63-8*b -: 8];
        for (int b = 0; b < 8; b++) m_nonce[b] = cfg_nonce[63-8*b -: 8];
`ifdef SALSA20_KEY256_EN
        m_k256 = cfg_setup[0];
`else
        m_k256 = 1'b0;
`endif
        m_d   = (cfg_setup[4:1] == 4'd0) ? 10 : int'(cfg_setup[4:1]);
        m_ctr = 64'd0;
        m_idx = 0;
        sb.delete();
    endtask

    task automatic push_expected(input logic [63:0] d);
        logic [63:0] c;
        if (m_idx == 0) gen_block();
        c = 64'd0;
        for (int k = 0; k < 8; k++) c = {c[55:0], m_ks[8*m_idx+k]};
        sb.push_back(d ^ c);
        m_idx++;
        if (m_idx == 8) begin
            m_idx = 0;
            m_ctr = m_ctr + 64'd1;
        end
    endtask

    // Stimulus tasks start and end just after a falling edge.
    task automatic wr(input logic [2:0] a, input logic [63:0] d, input logic with_init);
        write_enable = 1'b1;
        address      = a;
        in_w         = d;
        init         = with_init;
        @(negedge clk);
        write_enable = 1'b0;
        init         = 1'b0;
        if (a < 3'd4) cfg_key[a[1:0]] = d;
        else if (a == 3'd4) cfg_nonce = d;
        else if (a == 3'd5) cfg_setup = d;
        if (with_init) latch_cfg();
    endtask

    task automatic do_init();
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        latch_cfg();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        data_encdec = 1'b0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic xfer(input logic [63:0] d, input logic de, output logic rdy,
                        output logic v, output logic [63:0] o);
        in_w        = d;
        data_encdec = de;
        rdy         = ready;
        if (rdy && de) push_expected(d);
        @(negedge clk);
        v           = valid;
        o           = out_w;
        data_encdec = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_w, valid, ready, initialized} !== 67'd0) begin
            errors++;
            $display("FAIL reset_state got out=%h valid=%b ready=%b init=%b want all 0",
                     out_w, valid, ready, initialized);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vector128();
        int n; logic rdy, v; logic [63:0] o, exp;
        wr(3'd0, 64'h8000_0000_0000_0000, 1'b0);
        wr(3'd1, 64'd0, 1'b0);
        wr(3'd4, 64'd0, 1'b0);
        wr(3'd5, 64'h14, 1'b0);
        do_init();
        checks++;
        if (initialized !== 1'b1) begin
            errors++; $display("FAIL initialized got %b want 1", initialized);
        end
        wait_ready(n);
        checks++;
        if (n != 12) begin
            errors++; $display("FAIL v128_latency got %0d want 12", n);
        end
        xfer(64'd0, 1'b1, rdy, v, o);
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        checks++;
        if (v !== 1'b1 || o !== 64'h4DFA5E481DA23EA0) begin
            errors++;
            $display("FAIL v128_out got valid=%b out=%h want valid=1 out=4dfa5e481da23ea0", v, o);
        end
    endtask

    task automatic test_vector256();
        int n; logic rdy, v; logic [63:0] o, exp;
        wr(3'd2, 64'd0, 1'b0);
        wr(3'd3, 64'd0, 1'b0);
        wr(3'd5, 64'h15, 1'b0);
        do_init();
        wait_ready(n);
        xfer(64'd0, 1'b1, rdy, v, o);
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
`ifdef SALSA20_KEY256_EN
        exp = 64'hE3BE8FDD8BECA2E3;
`else
        exp = 64'h4DFA5E481DA23EA0;
`endif
        checks++;
        if (v !== 1'b1 || o !== exp) begin
            errors++;
            $display("FAIL v256_out got valid=%b out=%h want valid=1 out=%h", v, o, exp);
        end
    endtask

    task automatic test_stream();
        int n; logic rdy, v; logic [63:0] o, exp;
        wr(3'd0, 64'h0123_4567_89ab_cdef, 1'b0);
        wr(3'd1, 64'hfedc_ba98_7654_3210, 1'b0);
        wr(3'd2, 64'h1357_9bdf_0246_8ace, 1'b0);
        wr(3'd3, 64'h0f1e_2d3c_4b5a_6978, 1'b0);
        wr(3'd4, 64'hdead_beef_cafe_f00d, 1'b0);
        wr(3'd5, 64'h1, 1'b0);
        do_init();
        for (int i = 0; i < 88; i++) begin
            pt[i] = {$urandom, $urandom};
            wait_ready(n);
            checks++;
            if (n != ((i % 8 == 0) ? 12 : 0)) begin
                errors++;
                $display("FAIL stream_gap%0d got %0d want %0d", i, n, (i % 8 == 0) ? 12 : 0);
            end
            xfer(pt[i], 1'b1, rdy, v, o);
            exp = (sb.size() != 0) ? sb.pop_front() : 'x;
            ct[i] = o;
            checks++;
            if (v !== 1'b1 || o !== exp) begin
                errors++;
                $display("FAIL stream_enc%0d got valid=%b out=%h want valid=1 out=%h",
                         i, v, o, exp);
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_init();
        for (int i = 0; i < 88; i++) begin
            wait_ready(n);
            xfer(ct[i], 1'b1, rdy, v, o);
            exp = (sb.size() != 0) ? sb.pop_front() : 'x;
            checks++;
            if (v !== 1'b1 || o !== pt[i]) begin
                errors++;
                $display("FAIL stream_dec%0d got valid=%b out=%h want valid=1 out=%h",
                         i, v, o, pt[i]);
            end
        end
    endtask

    task automatic test_stall();
        int n; logic rdy, v; logic [63:0] o, exp;
        wr(3'd5, 64'h14, 1'b0);
        do_init();
        xfer(64'h5555_aaaa_5555_aaaa, 1'b1, rdy, v, o);
        checks++;
        if (v !== 1'b0) begin
            errors++; $display("FAIL notready_valid got %b want 0", v);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                for (int s = 0; s < 3; s++) begin
                    xfer({$urandom, $urandom}, 1'b0, rdy, v, o);
                    checks++;
                    if (v !== 1'b0) begin
                        errors++; $display("FAIL stall_valid%0d got %b want 0", s, v);
                    end
                end
            end
            wait_ready(n);
            xfer({$urandom, $urandom}, 1'b1, rdy, v, o);
            exp = (sb.size() != 0) ? sb.pop_front() : 'x;
            checks++;
            if (v !== 1'b1 || o !== exp) begin
                errors++;
                $display("FAIL stall_chunk%0d got valid=%b out=%h want valid=1 out=%h",
                         i, v, o, exp);
            end
        end
    endtask

    task automatic test_midreset();
        int n; logic rdy, v; logic [63:0] o, exp;
        do_init();
        for (int i = 0; i < 3; i++) begin
            wait_ready(n);
            xfer({$urandom, $urandom}, 1'b1, rdy, v, o);
            exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_w, valid, ready, initialized} !== 67'd0) begin
            errors++;
            $display("FAIL midreset_state got out=%h valid=%b ready=%b init=%b want all 0",
                     out_w, valid, ready, initialized);
        end
        @(negedge clk);
        rst = 1'b1;
        do_init();
        wait_ready(n);
        checks++;
        if (n != 12) begin
            errors++; $display("FAIL midreset_latency got %0d want 12", n);
        end
        xfer(64'h0123_0123_0123_0123, 1'b1, rdy, v, o);
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        checks++;
        if (v !== 1'b1 || o !== exp) begin
            errors++;
            $display("FAIL midreset_chunk got valid=%b out=%h want valid=1 out=%h", v, o, exp);
        end
    endtask

    task automatic test_rounds();
        int n; logic rdy, v; logic [63:0] o, exp;
        for (int r = 4; r <= 6; r += 2) begin
            wr(3'd5, 64'(r) << 1, 1'b0);
            do_init();
            for (int i = 0; i < 16; i++) begin
                wait_ready(n);
                checks++;
                if (n != ((i % 8 == 0) ? r + 2 : 0)) begin
                    errors++;
                    $display("FAIL rounds%0d_gap%0d got %0d want %0d", r, i, n,
                             (i % 8 == 0) ? r + 2 : 0);
                end
                xfer({$urandom, $urandom}, 1'b1, rdy, v, o);
                exp = (sb.size() != 0) ? sb.pop_front() : 'x;
                checks++;
                if (v !== 1'b1 || o !== exp) begin
                    errors++;
                    $display("FAIL rounds%0d_chunk%0d got valid=%b out=%h want valid=1 out=%h",
                             r, i, v, o, exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n; logic rdy, v; logic [63:0] o, exp;
        wr(3'd5, 64'h8, 1'b0);
        do_init();
        for (int i = 0; i < 10; i++) begin
            wait_ready(n);
            xfer({$urandom, $urandom}, 1'b1, rdy, v, o);
            exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        end
        // Re-init mid-block with a same-cycle key write
        wr(3'd0, 64'h7777_0000_1111_ffff, 1'b1);
        wait_ready(n);
        checks++;
        if (n != 6) begin
            errors++; $display("FAIL b2b_latency got %0d want 6", n);
        end
        for (int i = 0; i < 8; i++) begin
            wait_ready(n);
            xfer({$urandom, $urandom}, 1'b1, rdy, v, o);
            exp = (sb.size() != 0) ? sb.pop_front() : 'x;
            checks++;
            if (v !== 1'b1 || o !== exp) begin
                errors++;
                $display("FAIL b2b_chunk%0d got valid=%b out=%h want valid=1 out=%h",
                         i, v, o, exp);
            end
        end
    endtask

    initial begin
        rst          = 1'b0;
        init         = 1'b0;
        data_encdec  = 1'b0;
        write_enable = 1'b0;
        address      = 3'd0;
        in_w         = 64'd0;
        cfg_setup    = 64'd0;
        cfg_nonce    = 64'd0;
        for (int i = 0; i < 4; i++) cfg_key[i] = 64'd0;
        @(negedge clk);
        test_reset();
        test_vector128();
        test_vector256();
        test_stream();
        test_stall();
        test_midreset();
        test_rounds();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
